// File: rtl/mult_accumulator.sv
// Accumulates COUNT unsigned products from an upstream multiplier into one sum.
// Three-state flow: IDLE waits for start, ACCUM takes products, DONE holds the sum.
module mult_accumulator #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   product,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sum_valid,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT-1);
  localparam int         PAD      = ACC_WIDTH + 1 - 2*WIDTH;

  state_t               state;
  state_t               state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [7:0]           cnt;
  logic [ACC_WIDTH:0]   acc_ext;
  logic                 xfer;
  logic                 last;

  // One spare bit on top catches the carry out of the accumulator.
  assign acc_ext = {1'b0, acc} + {{PAD{1'b0}}, product};
  assign xfer    = in_ready && in_valid;
  assign last    = (cnt == LAST_CNT);
  assign sum     = acc;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)         state_next = ACCUM;
      ACCUM:   if (in_valid && last) state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (xfer) begin
      acc <= acc_ext[ACC_WIDTH-1:0];
      // The counter wraps on the final transfer so it never passes COUNT-1.
      cnt <= last ? 8'd0 : cnt + 8'd1;
      if (acc_ext[ACC_WIDTH]) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
